comp_fiber_tx_framer: RTL and testbench

- Transmit-side framer for the comparator fiber link, one stage upstream of the 160 MHz comparator receiver.
- Packs 48-bit payloads, normally from the PRBS generator, into 4-word 8b10b frames for the GTX TX user interface (16-bit TXDATA / TXCHARISK).
- Each frame is 1 K-char sync word followed by 3 data words.
- Inserts a latency-trigger marker on request and sends comma idles when the link is not running.

---
 rtl/comp_fiber_pkg.sv | 25 ++
 rtl/comp_fiber_tx_framer.sv | 116 +++++++++++
 tb/tb_comp_fiber_tx_framer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/comp_fiber_pkg.sv
// Shared framing constants and state encoding for the comparator fiber link.
// Both the TX framer and the RX deframer import this package.
package comp_fiber_pkg;

    localparam logic [7:0]  K_SYNC      = 8'hBC;    // K28.5, normal frame sync
    localparam logic [7:0]  K_LTNCY     = 8'hFC;    // K28.7, latency-trigger frame sync
    localparam logic [15:0] IDLE_WORD   = 16'hBCBC; // comma idle, sent with charisk 2'b11
    localparam int          FRAME_WORDS = 4;        // 1 sync word + 3 data words

    typedef logic [$clog2(FRAME_WORDS)-1:0] slot_t;
    localparam slot_t LAST_SLOT = slot_t'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Sync word: sequence number in the high byte, K character in the low byte.
    function automatic logic [15:0] sync_word(input logic [7:0] seq, input logic ltncy);
        return {seq, ltncy ? K_LTNCY : K_SYNC};
    endfunction

endpackage

// File: rtl/comp_fiber_tx_framer.sv
// Transmit framer for the comparator fiber link. Packs 48-bit payloads into
// 4-word 8b10b frames (sync + 3 data words) on the GTX TX user interface,
// sends comma idles while the link is down, and marks latency-trigger frames.
module comp_fiber_tx_framer
    import comp_fiber_pkg::*;
#(
    parameter int ALIGN_FRAMES = 16  // idle frames before the first data frame, 1..255
) (
    input  logic        CMP_TX_CLK160,
    input  logic        RST,
    input  logic        EN,
    input  logic [47:0] TX_DATA,
    input  logic        LTNCY_REQ,
    output logic [15:0] TXDATA,
    output logic [1:0]  TXCHARISK,
    output logic        DATA_RD,
    output logic        LTNCY_SENT,
    output logic        LTNCY_OVF,
    output logic [7:0]  SEQ,
    output logic [1:0]  STATE
);

    localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_FRAMES - 1);

    state_t      state;
    state_t      state_nxt;
    slot_t       slot;        // slot index of the word currently on TXDATA
    logic [7:0]  align_cnt;   // completed idle frames in ALIGN
    logic        pending;     // latency request waiting for the next RUN frame
    logic [47:0] hold;        // payload captured with DATA_RD

    logic        frame_end;
    logic [15:0] txdata_nxt;
    logic [1:0]  charisk_nxt;
    logic        data_rd_nxt;
    logic [7:0]  seq_nxt;
    logic        send_ltncy;

    assign frame_end = (slot == LAST_SLOT);
    assign STATE     = state;

    // Next-state decision; all transitions into or out of a frame happen on a slot3 boundary.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt = state;
        case (state)
            ST_IDLE:  if (EN && frame_end) state_nxt = ST_ALIGN;
            ST_ALIGN: begin
                if (!EN)                                       state_nxt = ST_IDLE;
                else if (frame_end && align_cnt == ALIGN_LAST) state_nxt = ST_RUN;
            end
            ST_RUN:   if (!EN) state_nxt = frame_end ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (frame_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Word to present next cycle: sync word when a RUN frame starts, data while a frame is open, else idle.
    always_comb begin
        txdata_nxt  = IDLE_WORD;
        charisk_nxt = 2'b11;
        data_rd_nxt = 1'b0;
        seq_nxt     = SEQ;
        send_ltncy  = 1'b0;
        if (frame_end && state_nxt == ST_RUN) begin
            seq_nxt     = (state == ST_RUN) ? SEQ + 8'd1 : 8'd0;
            send_ltncy  = pending;
            txdata_nxt  = sync_word(seq_nxt, pending);
            charisk_nxt = 2'b01;
            data_rd_nxt = 1'b1;
        end else if (state_nxt == ST_RUN || state_nxt == ST_DRAIN) begin
            charisk_nxt = 2'b00;
            case (slot)
                slot_t'(0): txdata_nxt = TX_DATA[15:0];  // payload is being captured on this edge
                slot_t'(1): txdata_nxt = hold[31:16];
                default:    txdata_nxt = hold[47:32];
            endcase
        end
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge CMP_TX_CLK160 or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            slot       <= '0;
            align_cnt  <= '0;
            pending    <= 1'b0;
            TXDATA     <= IDLE_WORD;
            TXCHARISK  <= 2'b11;
            DATA_RD    <= 1'b0;
            LTNCY_SENT <= 1'b0;
            LTNCY_OVF  <= 1'b0;
            SEQ        <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state      <= state_nxt;
            slot       <= slot + slot_t'(1);
            if (state == ST_ALIGN && frame_end) align_cnt <= align_cnt + 8'd1;
            else if (state != ST_ALIGN)         align_cnt <= '0;
            pending    <= (pending && !send_ltncy) || LTNCY_REQ;
            LTNCY_OVF  <= LTNCY_REQ && pending && !send_ltncy;
            LTNCY_SENT <= send_ltncy;
            TXDATA     <= txdata_nxt;
            TXCHARISK  <= charisk_nxt;
            DATA_RD    <= data_rd_nxt;
            SEQ        <= seq_nxt;
        end
    end

    // Payload holding register, loaded on the edge that ends the DATA_RD cycle.
    always_ff @(posedge CMP_TX_CLK160) begin
        // NOTE: pure datapath register without reset; it is always reloaded before any word reads it.
        if (DATA_RD) hold <= TX_DATA;
    end

endmodule

// File: tb/tb_comp_fiber_tx_framer.sv
// Directed bench for comp_fiber_tx_framer (ALIGN_FRAMES=2): reset, alignment,
// framing and SEQ wrap, latency markers, drain and mid-frame reset.
module tb_comp_fiber_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [47:0] tx_data;
    logic        ltncy_req;
    logic [15:0] txdata;
    logic [1:0]  txcharisk;
    logic        data_rd;
    logic        ltncy_sent;
    logic        ltncy_ovf;
    logic [7:0]  seq;
    logic [1:0]  state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_seq;
    logic [47:0] cur_data;

    comp_fiber_tx_framer #(.ALIGN_FRAMES(2)) dut (
        .CMP_TX_CLK160(clk),
        .RST          (rst),
        .EN           (en),
        .TX_DATA      (tx_data),
        .LTNCY_REQ    (ltncy_req),
        .TXDATA       (txdata),
        .TXCHARISK    (txcharisk),
        .DATA_RD      (data_rd),
        .LTNCY_SENT   (ltncy_sent),
        .LTNCY_OVF    (ltncy_ovf),
        .SEQ          (seq),
        .STATE        (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One RUN frame starting at its slot0 cycle; ends at the next slot0 cycle.
    task automatic frame_cycle(input logic [7:0] k, input logic sent, input logic [47:0] data_next,
                               input logic [3:0] req_mask, input logic [3:0] ovf_mask);
        logic [47:0] saved;
        logic [15:0] exp_word;
        saved = cur_data;
        n_cmp++; if (txdata !== {exp_seq, k}) begin n_err++; $display("FAIL sync_word: got %h expected %h", txdata, {exp_seq, k}); end
        n_cmp++; if (txcharisk !== 2'b01) begin n_err++; $display("FAIL sync_charisk: got %b expected 01", txcharisk); end
        n_cmp++; if (data_rd !== 1'b1) begin n_err++; $display("FAIL sync_data_rd: got %b expected 1", data_rd); end
        n_cmp++; if (seq !== exp_seq) begin n_err++; $display("FAIL seq: got %h expected %h", seq, exp_seq); end
        n_cmp++; if (ltncy_sent !== sent) begin n_err++; $display("FAIL ltncy_sent: got %b expected %b", ltncy_sent, sent); end
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL run_state: got %0d expected 2", state); end
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                exp_word = (s == 1) ? saved[15:0] : (s == 2) ? saved[31:16] : saved[47:32];
                n_cmp++; if (txdata !== exp_word) begin n_err++; $display("FAIL data_slot%0d: got %h expected %h", s, txdata, exp_word); end
                n_cmp++; if (txcharisk !== 2'b00) begin n_err++; $display("FAIL data_charisk%0d: got %b expected 00", s, txcharisk); end
                n_cmp++; if (data_rd !== 1'b0) begin n_err++; $display("FAIL data_rd_slot%0d: got %b expected 0", s, data_rd); end
                n_cmp++; if (ltncy_sent !== 1'b0) begin n_err++; $display("FAIL ltncy_sent_slot%0d: got %b expected 0", s, ltncy_sent); end
            end
            n_cmp++; if (ltncy_ovf !== ovf_mask[s]) begin n_err++; $display("FAIL ltncy_ovf_slot%0d: got %b expected %b", s, ltncy_ovf, ovf_mask[s]); end
            ltncy_req = req_mask[s];
            step();
            ltncy_req = 1'b0;
            if (s == 0) begin
                // Upstream advances only after the edge that consumed the payload.
                tx_data  = data_next;
                cur_data = data_next;
            end
        end
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; ltncy_req = 1'b0; tx_data = '0; cur_data = '0; exp_seq = 8'd0;
        #2;
        n_cmp++; if (txdata !== 16'hBCBC) begin n_err++; $display("FAIL reset_txdata: got %h expected bcbc", txdata); end
        n_cmp++; if (txcharisk !== 2'b11) begin n_err++; $display("FAIL reset_charisk: got %b expected 11", txcharisk); end
        n_cmp++; if (data_rd !== 1'b0) begin n_err++; $display("FAIL reset_data_rd: got %b expected 0", data_rd); end
        n_cmp++; if (seq !== 8'd0) begin n_err++; $display("FAIL reset_seq: got %h expected 00", seq); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_cmp++; if ({ltncy_sent, ltncy_ovf} !== 2'b00) begin n_err++; $display("FAIL reset_ltncy: got %b expected 00", {ltncy_sent, ltncy_ovf}); end
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            n_cmp++; if ({txdata, txcharisk, data_rd} !== {16'hBCBC, 2'b11, 1'b0})
                begin n_err++; $display("FAIL idle_cycle%0d: got %h/%b/%b expected bcbc/11/0", i, txdata, txcharisk, data_rd); end
        end
    endtask

    // Raise EN from IDLE, count ALIGN idles, then check the first two frames.
    task automatic test_align(input logic req_before);
        int align_words;
        bit reached;
        align_words = 0;
        reached = 0;
        cur_data = 48'h1111_2222_3333;
        tx_data  = cur_data;
        if (req_before) begin
            ltncy_req = 1'b1;
            step();
            ltncy_req = 1'b0;
        end
        en = 1'b1;
        for (int i = 0; i < 60 && !reached; i++) begin
            step();
            if (state == 2'd1) begin
                align_words++;
                n_cmp++; if ({txdata, txcharisk} !== {16'hBCBC, 2'b11})
                    begin n_err++; $display("FAIL align_word: got %h/%b expected bcbc/11", txdata, txcharisk); end
            end else if (state == 2'd2) begin
                reached = 1;
            end
        end
        n_cmp++; if (!reached) begin n_err++; $display("FAIL run_entry: got no RUN expected RUN within 60 cycles"); end
        n_cmp++; if (align_words != 8) begin n_err++; $display("FAIL align_count: got %0d expected 8", align_words); end
        exp_seq = 8'd0;
        frame_cycle(req_before ? 8'hFC : 8'hBC, req_before, 48'h4444_5555_6666, 4'b0000, 4'b0000);
        frame_cycle(8'hBC, 1'b0, 48'h7777_8888_9999, 4'b0000, 4'b0000);
    endtask

    task automatic test_latency;
        frame_cycle(8'hBC, 1'b0, 48'hA001_A002_A003, 4'b0100, 4'b0000); // request in slot2
        frame_cycle(8'hFC, 1'b1, 48'hB001_B002_B003, 4'b0110, 4'b1000); // two requests merge
        frame_cycle(8'hFC, 1'b1, 48'hC001_C002_C003, 4'b0001, 4'b0000); // request in slot0
        frame_cycle(8'hFC, 1'b1, 48'hD001_D002_D003, 4'b0000, 4'b0000);
        frame_cycle(8'hBC, 1'b0, 48'hE001_E002_E003, 4'b0000, 4'b0000);
    endtask

    task automatic test_back_to_back;
        logic [15:0] v;
        for (int i = 0; i < 260; i++) begin
            v = i[15:0];
            frame_cycle(8'hBC, 1'b0, {v ^ 16'h5A5A, ~v, v}, 4'b0000, 4'b0000);
        end
    endtask

    task automatic test_drain;
        logic [47:0] saved;
        logic [7:0]  last_seq;
        saved = cur_data;
        last_seq = exp_seq;
        n_cmp++; if (txcharisk !== 2'b01) begin n_err++; $display("FAIL drain_sync: got %b expected 01", txcharisk); end
        step();
        tx_data = 48'hF00D_F00D_F00D;
        en = 1'b0;
        n_cmp++; if (txdata !== saved[15:0]) begin n_err++; $display("FAIL drain_slot1: got %h expected %h", txdata, saved[15:0]); end
        step();
        n_cmp++; if ({state, txdata, txcharisk} !== {2'd3, saved[31:16], 2'b00})
            begin n_err++; $display("FAIL drain_slot2: got %0d/%h/%b expected 3/%h/00", state, txdata, txcharisk, saved[31:16]); end
        step();
        n_cmp++; if ({state, txdata, txcharisk} !== {2'd3, saved[47:32], 2'b00})
            begin n_err++; $display("FAIL drain_slot3: got %0d/%h/%b expected 3/%h/00", state, txdata, txcharisk, saved[47:32]); end
        step();
        n_cmp++; if ({state, txdata, txcharisk, data_rd} !== {2'd0, 16'hBCBC, 2'b11, 1'b0})
            begin n_err++; $display("FAIL drain_idle: got %0d/%h/%b/%b expected 0/bcbc/11/0", state, txdata, txcharisk, data_rd); end
        n_cmp++; if (seq !== last_seq) begin n_err++; $display("FAIL drain_seq_hold: got %h expected %h", seq, last_seq); end
        step(); step(); step();
        test_align(1'b1);  // full align period again; request made in IDLE marks the first frame
    endtask

    task automatic test_reset_mid_frame;
        ltncy_req = 1'b1;  // sets pending during slot0; reset must discard it
        step();
        ltncy_req = 1'b0;
        step();
        n_cmp++; if ({state, txcharisk} !== {2'd2, 2'b00})
            begin n_err++; $display("FAIL pre_reset_slot2: got %0d/%b expected 2/00", state, txcharisk); end
        rst = 1'b1;
        en  = 1'b0;
        #1;
        n_cmp++; if ({txdata, txcharisk} !== {16'hBCBC, 2'b11})
            begin n_err++; $display("FAIL async_reset_word: got %h/%b expected bcbc/11", txdata, txcharisk); end
        n_cmp++; if ({state, seq, data_rd} !== {2'd0, 8'd0, 1'b0})
            begin n_err++; $display("FAIL async_reset_ctrl: got %0d/%h/%b expected 0/00/0", state, seq, data_rd); end
        step();
        rst = 1'b0;
        step();
        test_align(1'b0);  // first frame must carry K_SYNC: pending was cleared
    endtask

    initial begin
        test_reset();
        test_align(1'b0);
        test_latency();
        test_back_to_back();
        test_drain();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
